// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- MEM-stage load/store unit of the 5-stage RV32I pipeline.
//
// Sits behind the EX/MEM register. Each load or store runs one data-bus
// transaction through a req/gnt/rvalid handshake. The rest of the pipeline is
// stalled until that transaction completes. Store data is replicated across the
// byte lanes with matching byte enables. Load data is shifted down and sign- or
// zero-extended. The unit also selects the write-back value (DMEM, ALU or PC+4).
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mem_valid             EX/MEM holds a real instruction (0 = bubble)
//   mem_alu               effective address / ALU result
//   mem_pc, mem_rs2       instruction PC, store data
//   mem_MemRW             1 = store
//   mem_regWEn            register write enable from decode
//   mem_WBSel             00 DMEM, 01 ALU, 10 PC+4, 11 ALU
//   mem_ctrl_datain       store size: 00 byte, 01 half, 1x word
//   mem_ctrl_dataOutAddj  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, else LW
//   dbus_*                data bus (req/we/addr/be/wdata out, gnt/rvalid/rdata in)
//   mem_stall             holds PC, IF/ID, ID/EX and EX/MEM while a transaction is open
//   wb_data, wb_regWEn    write-back value and its enable for MEM/WB
//   misalign_err          combinational misaligned-access flag
//   bus_err               one-cycle pulse in DONE when the access timed out
module mem_stage_lsu #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_rs2,
  input  logic        mem_MemRW,
  input  logic        mem_regWEn,
  input  logic [1:0]  mem_WBSel,
  input  logic [1:0]  mem_ctrl_datain,
  input  logic [2:0]  mem_ctrl_dataOutAddj,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic        wb_regWEn,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [31:0]       ld_buf;
  logic [2:0]        ld_type_p0;
  logic [1:0]        ld_off_p0;

  logic acc;
  logic is_half;
  logic is_word;
  logic misaligned;
  logic tmo_hit;
  logic start;

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << {off[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated so every enabled lane carries the right bytes.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
    case (size)
      2'b00:   store_wdata = {4{rs2[7:0]}};
      2'b01:   store_wdata = {2{rs2[15:0]}};
      default: store_wdata = rs2;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0 and extend it to 32 bits.
  function automatic logic [31:0] load_align(input logic [2:0] typ, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic        [31:0] sh;
    logic signed [7:0]  sb;
    logic signed [15:0] sh16;
    sh   = rdata >> {off, 3'b000};
    sb   = sh[7:0];
    sh16 = sh[15:0];
    case (typ)
      3'b000:  load_align = 32'(sb);
      3'b001:  load_align = 32'(sh16);
      3'b100:  load_align = {24'd0, sh[7:0]};
      3'b101:  load_align = {16'd0, sh[15:0]};
      default: load_align = rdata;
    endcase
  endfunction

  // Access size decode: stores use the store-size field, loads the load-type field.
  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    if (mem_MemRW) begin
      is_half = (mem_ctrl_datain == 2'b01);
      is_word = mem_ctrl_datain[1];
    end else begin
      case (mem_ctrl_dataOutAddj)
        3'b000, 3'b100: ;
        3'b001, 3'b101: is_half = 1'b1;
        default:        is_word = 1'b1;
      endcase
    end
  end

  assign acc          = mem_valid & (mem_MemRW | (mem_WBSel == 2'b00));
  assign misaligned   = (is_half & mem_alu[0]) | (is_word & (mem_alu[1:0] != 2'b00));
  assign misalign_err = acc & misaligned;
  assign start        = (state == S_IDLE) & acc & ~misaligned;

  // The counter sits at BUS_TIMEOUT-1 during the last permitted REQ/WAIT cycle.
  assign tmo_hit      = (tmo_cnt == CNT_W'(BUS_TIMEOUT - 1));

  assign mem_stall    = start | (state == S_REQ) | (state == S_WAIT);
  assign wb_regWEn    = mem_regWEn & mem_valid & ~mem_stall & ~misalign_err & ~bus_err;

  always_comb begin
    case (mem_WBSel)
      2'b00:   wb_data = ld_buf;
      2'b10:   wb_data = mem_pc + 32'd4;
      default: wb_data = mem_alu;
    endcase
  end

  // Issue stage: load shape captured alongside the bus request
  always_ff @(posedge clk) begin
    if (start) begin
      ld_type_p0 <= mem_ctrl_dataOutAddj;
      ld_off_p0  <= mem_alu[1:0];
    end
  end

  // Transaction FSM: bus outputs registered at issue, held until gnt
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      ld_buf     <= '0;
      tmo_cnt    <= '0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus_err <= 1'b0;
          if (start) begin
            state      <= S_REQ;
            dbus_req   <= 1'b1;
            dbus_we    <= mem_MemRW;
            dbus_addr  <= {mem_alu[31:2], 2'b00};
            dbus_be    <= mem_MemRW ? store_be(mem_ctrl_datain, mem_alu[1:0]) : 4'b1111;
            dbus_wdata <= mem_MemRW ? store_wdata(mem_ctrl_datain, mem_rs2) : 32'd0;
            tmo_cnt    <= '0;
          end
        end
        S_REQ: begin
          if (dbus_gnt && dbus_we) begin
            dbus_req <= 1'b0;
            state    <= S_DONE;
          end else if (tmo_hit) begin
            dbus_req <= 1'b0;
            bus_err  <= 1'b1;
            state    <= S_DONE;
          end else if (dbus_gnt) begin
            dbus_req <= 1'b0;
            tmo_cnt  <= tmo_cnt + 1'b1;
            state    <= S_WAIT;
          end else begin
            tmo_cnt  <= tmo_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (dbus_rvalid) begin
            ld_buf <= load_align(ld_type_p0, ld_off_p0, dbus_rdata);
            state  <= S_DONE;
          end else if (tmo_hit) begin
            bus_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          bus_err <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int BUS_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_alu;
  logic [31:0] mem_pc;
  logic [31:0] mem_rs2;
  logic        mem_MemRW;
  logic        mem_regWEn;
  logic [1:0]  mem_WBSel;
  logic [1:0]  mem_ctrl_datain;
  logic [2:0]  mem_ctrl_dataOutAddj;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic [31:0] wb_data;
  logic        wb_regWEn;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_ld;

  always #5 clk = ~clk;

  mem_stage_lsu #(.BUS_TIMEOUT(BUS_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_alu(mem_alu), .mem_pc(mem_pc), .mem_rs2(mem_rs2),
    .mem_MemRW(mem_MemRW), .mem_regWEn(mem_regWEn), .mem_WBSel(mem_WBSel),
    .mem_ctrl_datain(mem_ctrl_datain), .mem_ctrl_dataOutAddj(mem_ctrl_dataOutAddj),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata), .mem_stall(mem_stall), .wb_data(wb_data),
    .wb_regWEn(wb_regWEn), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on byte counts and offsets.
  function automatic int nbytes(input logic store, input logic [1:0] ssize, input logic [2:0] lt);
    if (store) return (ssize == 2'd0) ? 1 : (ssize == 2'd1) ? 2 : 4;
    if (lt == 3'd0 || lt == 3'd4) return 1;
    if (lt == 3'd1 || lt == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] lt, input int off, input logic [31:0] d);
    longint v;
    longint sh;
    sh = longint'(d) / (longint'(1) << (8 * off));
    case (lt)
      3'd0: begin v = sh % 256;   if (v >= 128)   v = v - 256;   end
      3'd4: v = sh % 256;
      3'd1: begin v = sh % 65536; if (v >= 32768) v = v - 65536; end
      3'd5: v = sh % 65536;
      default: v = longint'(d);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] be_model(input int nb, input int off);
    if (nb == 1) return 4'(1 << off);
    if (nb == 2) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] wd_model(input int nb, input logic [31:0] rs2);
    if (nb == 1) return (rs2 % 32'd256) * 32'h0101_0101;
    if (nb == 2) return (rs2 % 32'd65536) * 32'h0001_0001;
    return rs2;
  endfunction

  // Present one instruction to MEM, play the bus side, check the result, then one bubble.
  // g: REQ cycles before gnt; r: WAIT cycles before rvalid; drop_rv: never send rvalid.
  task automatic run_instr(input string tag, input logic valid, input logic store,
                           input logic [1:0] wbsel, input logic regwen,
                           input logic [1:0] ssize, input logic [2:0] lt,
                           input logic [31:0] addr, input logic [31:0] pc,
                           input logic [31:0] rs2, input logic [31:0] rdata,
                           input int g, input int r, input logic drop_rv);
    int nb, off, stall_cnt, req_cnt, wait_idx, exp_stall;
    logic acc, mis, tmo, granted, done, regwen_stall, req_seen, unstable;
    logic [31:0] s_addr, s_wdata, exp_wb;
    logic [3:0] s_be;
    logic s_we;
    nb  = nbytes(store, ssize, lt);
    off = int'(addr % 32'd4);
    acc = valid && (store || wbsel == 2'b00);
    mis = acc && (off % nb != 0);
    tmo = acc && !mis && !store && drop_rv;
    stall_cnt = 0; req_cnt = 0; wait_idx = 0;
    granted = 0; done = 0; regwen_stall = 0; req_seen = 0; unstable = 0;
    s_addr = '0; s_wdata = '0; s_be = '0; s_we = 1'b0;

    @(negedge clk);
    mem_valid = valid; mem_MemRW = store; mem_WBSel = wbsel; mem_regWEn = regwen;
    mem_ctrl_datain = ssize; mem_ctrl_dataOutAddj = lt;
    mem_alu = addr; mem_pc = pc; mem_rs2 = rs2;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    #1;
    chk({tag, ":misalign_err"}, 32'(misalign_err), 32'(mis));

    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        #1;
      end
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = $urandom;
      if (mem_stall) begin
        stall_cnt++;
        if (wb_regWEn) regwen_stall = 1;
        if (dbus_req) begin
          if (!req_seen) begin
            s_addr = dbus_addr; s_be = dbus_be; s_wdata = dbus_wdata; s_we = dbus_we;
            req_seen = 1;
          end else if (dbus_addr !== s_addr || dbus_be !== s_be ||
                       dbus_wdata !== s_wdata || dbus_we !== s_we) begin
            unstable = 1;
          end
          if (req_cnt == g) begin
            dbus_gnt = 1'b1;
            granted  = 1;
          end else begin
            dbus_rvalid = 1'($urandom_range(0, 1));
          end
          req_cnt++;
        end else if (granted) begin
          if (!drop_rv && wait_idx == r) begin
            dbus_rvalid = 1'b1;
            dbus_rdata  = rdata;
          end else begin
            dbus_gnt = 1'($urandom_range(0, 1));
          end
          wait_idx++;
        end
      end else begin
        done = 1;
      end
    end
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;

    if (!done) begin
      chk({tag, ":completion"}, 32'd0, 32'd1);
    end else begin
      if (acc && !mis && !store && !drop_rv) model_ld = ld_model(lt, off, rdata);
      if (!acc || mis)  exp_stall = 0;
      else if (store)   exp_stall = 2 + g;
      else if (tmo)     exp_stall = 1 + BUS_TIMEOUT;
      else              exp_stall = 3 + g + r;
      exp_wb = (wbsel == 2'b00) ? model_ld : (wbsel == 2'b10) ? pc + 32'd4 : addr;
      chk({tag, ":stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
      chk({tag, ":wb_data"}, wb_data, exp_wb);
      chk({tag, ":wb_regWEn"}, 32'(wb_regWEn), 32'(regwen && valid && !mis && !tmo));
      chk({tag, ":bus_err"}, 32'(bus_err), 32'(tmo));
      chk({tag, ":req_seen"}, 32'(req_seen), 32'(acc && !mis));
      if (acc && !mis) begin
        chk({tag, ":addr"}, s_addr, addr - (addr % 32'd4));
        chk({tag, ":we"}, 32'(s_we), 32'(store));
        chk({tag, ":be"}, 32'(s_be), 32'(store ? be_model(nb, off) : 4'hF));
        if (store) chk({tag, ":wdata"}, s_wdata, wd_model(nb, rs2));
        chk({tag, ":stable"}, 32'(unstable), 32'd0);
        chk({tag, ":regwen_in_stall"}, 32'(regwen_stall), 32'd0);
      end
    end

    @(negedge clk);
    mem_valid = 1'b0; mem_WBSel = 2'b01; mem_regWEn = 1'b1; mem_alu = $urandom;
    #1;
    chk({tag, ":bubble_req"}, 32'(dbus_req), 32'd0);
    chk({tag, ":bubble_stall"}, 32'(mem_stall), 32'd0);
    chk({tag, ":bubble_bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, ":bubble_regwen"}, 32'(wb_regWEn), 32'd0);
    chk({tag, ":bubble_wb_data"}, wb_data, mem_alu);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    logic st;
    logic [1:0] ws;
    logic [31:0] a;

    reset = 1'b1; mem_valid = 1'b0; mem_alu = '0; mem_pc = '0; mem_rs2 = '0;
    mem_MemRW = 1'b0; mem_regWEn = 1'b0; mem_WBSel = 2'b00; mem_ctrl_datain = '0;
    mem_ctrl_dataOutAddj = '0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    model_ld = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst:req", 32'(dbus_req), 32'd0);
    chk("rst:we", 32'(dbus_we), 32'd0);
    chk("rst:addr", dbus_addr, 32'd0);
    chk("rst:be", 32'(dbus_be), 32'd0);
    chk("rst:wdata", dbus_wdata, 32'd0);
    chk("rst:stall", 32'(mem_stall), 32'd0);
    chk("rst:bus_err", 32'(bus_err), 32'd0);
    chk("rst:ld_buf", wb_data, 32'd0);
    reset = 1'b0;

    // Directed cases
    run_instr("sb_1003", 1, 1, 2'b01, 0, 2'b00, 3'd0, 32'h0000_1003, 32'h100, 32'h0000_00A5, 0, 0, 0, 0);
    chk("sb_1003:be_const", 32'(be_model(1, 3)), 32'h8);
    run_instr("lh_2002", 1, 0, 2'b00, 1, 2'b00, 3'd1, 32'h0000_2002, 32'h104, 0, 32'h8001_1234, 0, 1, 0);
    chk("lh_2002:value", model_ld, 32'hFFFF_8001);
    run_instr("lbu_2001", 1, 0, 2'b00, 1, 2'b00, 3'd4, 32'h0000_2001, 32'h108, 0, 32'h0000_F000, 0, 0, 0);
    chk("lbu_2001:value", model_ld, 32'h0000_00F0);
    run_instr("lw_mis", 1, 0, 2'b00, 1, 2'b00, 3'd2, 32'h0000_2002, 32'h10C, 0, 32'h1111_1111, 0, 0, 0);
    run_instr("sh_mis", 1, 1, 2'b01, 0, 2'b01, 3'd0, 32'h0000_3001, 32'h110, 32'h1234, 0, 0, 0, 0);
    run_instr("sh_3002", 1, 1, 2'b01, 0, 2'b01, 3'd0, 32'h0000_3002, 32'h114, 32'hCAFE_BEEF, 0, 2, 0, 0);
    run_instr("sw_3004", 1, 1, 2'b01, 0, 2'b10, 3'd0, 32'h0000_3004, 32'h118, 32'h1357_9BDF, 0, 1, 0, 0);
    run_instr("lb_neg", 1, 0, 2'b00, 1, 2'b00, 3'd0, 32'h0000_4003, 32'h11C, 0, 32'h8300_0000, 1, 2, 0);
    run_instr("lw_4000", 1, 0, 2'b00, 1, 2'b00, 3'd2, 32'h0000_4000, 32'h120, 0, 32'hA5A5_0F0F, 0, 0, 0);
    run_instr("pc4_wrap", 1, 0, 2'b10, 1, 2'b00, 3'd0, 32'h0000_0010, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    run_instr("alu_pass", 1, 0, 2'b11, 1, 2'b00, 3'd0, 32'h7654_3210, 32'h124, 0, 0, 0, 0, 0);
    run_instr("bubble_ld", 0, 0, 2'b00, 1, 2'b00, 3'd2, 32'h0000_5000, 32'h128, 0, 0, 0, 0, 0);
    run_instr("ld_timeout", 1, 0, 2'b00, 1, 2'b00, 3'd2, 32'h0000_6000, 32'h12C, 0, 0, 0, 0, 1);

    // Reset while waiting for read data, then a stray rvalid
    @(negedge clk);
    mem_valid = 1'b1; mem_MemRW = 1'b0; mem_WBSel = 2'b00; mem_regWEn = 1'b1;
    mem_ctrl_dataOutAddj = 3'd2; mem_alu = 32'h0000_7000; mem_pc = 32'h130;
    @(negedge clk);
    #1;
    chk("rstw:req_up", 32'(dbus_req), 32'd1);
    dbus_gnt = 1'b1;
    @(negedge clk);
    #1;
    dbus_gnt = 1'b0;
    chk("rstw:in_wait", 32'(mem_stall & ~dbus_req), 32'd1);
    reset = 1'b1;
    mem_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_ld = '0;
    dbus_rvalid = 1'b1;
    dbus_rdata = 32'hDEAD_BEEF;
    chk("rstw:req", 32'(dbus_req), 32'd0);
    chk("rstw:addr", dbus_addr, 32'd0);
    chk("rstw:be", 32'(dbus_be), 32'd0);
    chk("rstw:stall", 32'(mem_stall), 32'd0);
    chk("rstw:wb_data", wb_data, model_ld);
    @(negedge clk);
    #1;
    dbus_rvalid = 1'b0;
    chk("rstw:late_rvalid", wb_data, model_ld);
    chk("rstw:req_after", 32'(dbus_req), 32'd0);
    chk("rstw:stall_after", 32'(mem_stall), 32'd0);
    chk("rstw:regwen", 32'(wb_regWEn), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      st = (kind == 0);
      ws = (kind == 2) ? 2'($urandom_range(1, 3)) : (kind == 1) ? 2'b00 : 2'($urandom_range(0, 3));
      run_instr("rand", 1'($urandom_range(0, 7) != 0), st, ws, 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a,
                ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'($urandom),
                32'($urandom), 32'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
